// File: rtl/uart_rcv_cfg.sv
// Parametrised UART receiver: DATA_BITS data bits LSB first, optional even/odd parity, one stop bit.
// Latency: rdy rises BAUD_DIV/2 + (1+DATA_BITS+(PARITY!=0))*BAUD_DIV + 1 clk after the RX_safe start edge.
// Backpressure: none; a frame completing while rdy is still set overwrites rx_data and sets overrun.
module uart_rcv_cfg #(
   parameter int DATA_BITS = 8,
   parameter int BAUD_DIV  = 2604,
   parameter int PARITY    = 0,
   parameter int CNT_W     = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] HALF     = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_q;
   logic                 rx_meta;
   logic                 rx_safe;
   logic                 rx_prev;
   logic                 strobe;
   logic                 par_x;
   logic                 par_bad;

   // mid-bit sample point: counter expiry while a frame is in progress
   assign strobe  = (state != IDLE) && (baud_cnt == '0);
   // parity over the full data word plus the parity bit being sampled now
   assign par_x   = (^shreg) ^ rx_safe;
   assign par_bad = (PARITY == 2) ? ~par_x : par_x;

   // two-flop synchroniser plus one delayed copy for start-edge detection; idle-high reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_safe <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_safe <= rx_meta;
         rx_prev <= rx_safe;
      end
   end

   // frame FSM with baud counter, bit counter, shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_err_q  <= 1'b0;
         rx_data    <= '0;
         rdy        <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // consumer acknowledge; a completion later in this block overrides it
         if (clr_rdy) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end

         if (strobe) begin
            baud_cnt <= RELOAD;
         end else if (state != IDLE) begin
            baud_cnt <= baud_cnt - 1'b1;
         end

         case (state)
            IDLE: begin
               // only a true 1->0 edge starts a frame, so a held-low break cannot retrigger
               if (!rx_safe && rx_prev) begin
                  state    <= START;
                  baud_cnt <= HALF;
               end
            end
            START: begin
               if (strobe) begin
                  if (!rx_safe) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (strobe) begin
                  shreg   <= {rx_safe, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= (PARITY != 0) ? PAR : STOP;
                  end
               end
            end
            PAR: begin
               if (strobe) begin
                  par_err_q <= par_bad;
                  state     <= STOP;
               end
            end
            STOP: begin
               // deliver at mid-stop so the next start edge can be caught in the second half
               if (strobe) begin
                  state      <= IDLE;
                  rx_data    <= shreg;
                  rdy        <= 1'b1;
                  frame_err  <= ~rx_safe;
                  parity_err <= (PARITY != 0) ? par_err_q : 1'b0;
                  if (rdy && !clr_rdy) begin
                     overrun <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Bench for uart_rcv_cfg: three instances (8N1, 8E1, 7O1) at BAUD_DIV=16 driven by a frame generator.
// Expected frames are queued as they are sent and compared when an instance presents a new frame.
// Flag, latency, overrun and reset behaviour are compared directly in the stimulus sequence.
module tb_uart_rcv_cfg;

   localparam int BD = 16;

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_in [3];
   logic       clr   [3];
   logic       rdy_w [3];
   logic       perr_w[3];
   logic       ferr_w[3];
   logic       ovr_w [3];
   logic [7:0] d0;
   logic [7:0] d1;
   logic [6:0] d2;
   logic [8:0] dat   [3];
   logic       rdy_q [3];
   logic [8:0] dat_q [3];
   exp_t       sbq[$];
   int         total = 0;
   int         bad   = 0;
   int         lat;

   always #5 clk = ~clk;

   assign dat[0] = {1'b0, d0};
   assign dat[1] = {1'b0, d1};
   assign dat[2] = {2'b0, d2};

   uart_rcv_cfg #(.DATA_BITS(8), .BAUD_DIV(BD), .PARITY(0), .CNT_W(5)) u0 (
      .clk(clk), .rst_n(rst_n), .RX(rx_in[0]), .clr_rdy(clr[0]), .rx_data(d0),
      .rdy(rdy_w[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .overrun(ovr_w[0]));

   uart_rcv_cfg #(.DATA_BITS(8), .BAUD_DIV(BD), .PARITY(1), .CNT_W(5)) u1 (
      .clk(clk), .rst_n(rst_n), .RX(rx_in[1]), .clr_rdy(clr[1]), .rx_data(d1),
      .rdy(rdy_w[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .overrun(ovr_w[1]));

   uart_rcv_cfg #(.DATA_BITS(7), .BAUD_DIV(BD), .PARITY(2), .CNT_W(5)) u2 (
      .clk(clk), .rst_n(rst_n), .RX(rx_in[2]), .clr_rdy(clr[2]), .rx_data(d2),
      .rdy(rdy_w[2]), .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .overrun(ovr_w[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input int inst, input logic v);
      rx_in[inst] = v;
   endtask

   // one full frame; called and returns on a negedge, line left at the stop-bit level
   task automatic send(input int inst, input logic [8:0] d, input int nbits,
                       input int pmode, input logic pbit, input logic stopb);
      exp_t e;
      logic x;
      x = pbit;
      for (int i = 0; i < nbits; i++) x = x ^ d[i];
      e.inst = inst;
      e.data = d;
      e.perr = (pmode == 1) ? x : (pmode == 2) ? ~x : 1'b0;
      e.ferr = ~stopb;
      sbq.push_back(e);
      drive(inst, 1'b0);
      repeat (BD) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         drive(inst, d[i]);
         repeat (BD) @(negedge clk);
      end
      if (pmode != 0) begin
         drive(inst, pbit);
         repeat (BD) @(negedge clk);
      end
      drive(inst, stopb);
      repeat (BD) @(negedge clk);
   endtask

   task automatic clear(input int inst);
      clr[inst] = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_rdy", rdy_w[inst], 1'b0);
      chk("clr_ovr", ovr_w[inst], 1'b0);
      @(negedge clk);
      clr[inst] = 1'b0;
   endtask

   // scoreboard: a new frame is a rising rdy or a changed word while rdy stays high
   initial begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         rdy_q[i] = 1'b0;
         dat_q[i] = '0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (rst_n === 1'b1 && rdy_w[i] === 1'b1 && (!rdy_q[i] || dat[i] != dat_q[i])) begin
               chk("sb_has_entry", sbq.size() > 0, 1'b1);
               if (sbq.size() > 0) begin
                  e = sbq.pop_front();
                  chk("sb_inst", i, e.inst);
                  chk("sb_data", dat[i], e.data);
                  chk("sb_perr", perr_w[i], e.perr);
                  chk("sb_ferr", ferr_w[i], e.ferr);
               end
            end
            rdy_q[i] = rdy_w[i];
            dat_q[i] = dat[i];
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_in[i] = 1'b1;
         clr[i]   = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_data", dat[i], 9'h0);
         chk("rst_rdy",  rdy_w[i], 1'b0);
         chk("rst_perr", perr_w[i], 1'b0);
         chk("rst_ferr", ferr_w[i], 1'b0);
         chk("rst_ovr",  ovr_w[i], 1'b0);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1 frame and start-to-rdy latency (2 sync clocks + 153)
      lat = 0;
      fork
         send(0, 9'h0A5, 8, 0, 1'b0, 1'b1);
         begin
            while (rdy_w[0] !== 1'b1 && lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      chk("latency", lat, 155);
      chk("a5_data", dat[0], 9'h0A5);
      clear(0);

      // even parity: correct then wrong parity bit
      send(1, 9'h037, 8, 1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      clear(1);
      send(1, 9'h037, 8, 1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("par_bad_flag", perr_w[1], 1'b1);
      clear(1);

      // framing error followed by a held-low break: one frame only, no retrigger
      send(0, 9'h05A, 8, 0, 1'b0, 1'b0);
      clear(0);
      chk("ferr_hold", ferr_w[0], 1'b1);
      repeat (5 * BD) @(negedge clk);
      drive(0, 1'b1);
      repeat (12 * BD) @(negedge clk);
      chk("break_no_rdy", rdy_w[0], 1'b0);
      chk("break_sb_empty", sbq.size(), 0);
      send(0, 9'h03C, 8, 0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      clear(0);

      // 3-clk glitch is a false start; flags untouched, receiver still usable
      drive(0, 1'b0);
      repeat (3) @(negedge clk);
      drive(0, 1'b1);
      repeat (3 * BD) @(negedge clk);
      chk("glitch_rdy",  rdy_w[0], 1'b0);
      chk("glitch_ferr", ferr_w[0], 1'b0);
      chk("glitch_sb",   sbq.size(), 0);
      send(0, 9'h096, 8, 0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      clear(0);

      // back-to-back without acknowledge -> overrun
      send(0, 9'h011, 8, 0, 1'b0, 1'b1);
      send(0, 9'h022, 8, 0, 1'b0, 1'b1);
      chk("ovr_set",  ovr_w[0], 1'b1);
      chk("ovr_rdy",  rdy_w[0], 1'b1);
      chk("ovr_data", dat[0], 9'h022);
      clear(0);

      // acknowledge in the completion cycle of the second frame: completion wins
      send(0, 9'h033, 8, 0, 1'b0, 1'b1);
      fork
         send(0, 9'h044, 8, 0, 1'b0, 1'b1);
         begin
            repeat (154) @(negedge clk);
            clr[0] = 1'b1;
            @(negedge clk);
            clr[0] = 1'b0;
         end
      join
      chk("race_rdy",  rdy_w[0], 1'b1);
      chk("race_ovr",  ovr_w[0], 1'b0);
      chk("race_data", dat[0], 9'h044);
      clear(0);

      // 7O1: seven ones with parity 0 is correct odd parity
      send(2, 9'h07F, 7, 2, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("odd_rdy", rdy_w[2], 1'b1);

      // reset in the middle of the data bits of a partial frame
      drive(2, 1'b0);
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(2, i[0]);
         repeat (BD) @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data", dat[2], 9'h0);
      chk("mid_rst_rdy",  rdy_w[2], 1'b0);
      chk("mid_rst_perr", perr_w[2], 1'b0);
      chk("mid_rst_ferr", ferr_w[2], 1'b0);
      chk("mid_rst_ovr",  ovr_w[2], 1'b0);
      drive(2, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * BD) @(negedge clk);
      chk("post_rst_rdy", rdy_w[2], 1'b0);
      send(2, 9'h001, 7, 2, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("post_rst_data", dat[2], 9'h001);
      clear(2);

      repeat (2 * BD) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rcv_cfg.md
Name: uart_rcv_cfg

Overview:
Parametrised UART receiver that replaces the fixed 8N1 receiver used by the Segway command link. The baud divisor, data width and parity mode are set by parameters. The block adds false-start rejection, parity checking, framing-error detection and overrun detection. It sits between the asynchronous RX pin and the command/packet layer, which consumes rx_data on rdy and acknowledges with clr_rdy.

Parameters:
DATA_BITS, 8, number of data bits per frame, legal range 5..9, sent LSB first
BAUD_DIV, 2604, clk cycles per bit, minimum 4
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
CNT_W, 12, baud counter width; must hold BAUD_DIV-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
RX  in  1  serial input, asynchronous, idles high
clr_rdy  in  1  consumer acknowledge; clears rdy and overrun
rx_data  out  DATA_BITS  last received data word
rdy  out  1  new frame available
parity_err  out  1  parity mismatch on the frame currently presented
frame_err  out  1  stop bit sampled low on the frame currently presented
overrun  out  1  sticky: a frame completed while rdy was still 1

Behaviour:
- Synchroniser: RX passes through a 2-flop synchroniser to produce RX_safe. Both flops reset to 1. All decisions use RX_safe; the RX-to-RX_safe latency is 2 clk.
- Reset values: rx_data = 0, rdy = 0, parity_err = 0, frame_err = 0, overrun = 0, state = IDLE, baud counter = 0, bit counter = 0.
- Baud counter: down-counter of CNT_W bits. The one-cycle sample strobe fires when the counter equals 0 in any non-IDLE state. On the strobe the counter reloads with BAUD_DIV-1; otherwise it decrements.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - Start is detected on a falling edge of RX_safe only (RX_safe 0 and the previous RX_safe 1). A line held low (break) after a frame does not retrigger.
  - On detection: go to START and load the counter with BAUD_DIV/2 - 1 (integer division).
- START: on the strobe (mid start bit):
  - RX_safe = 0: go to DATA and clear the bit counter.
  - RX_safe = 1: false start. Return to IDLE; no flags change, rdy unaffected.
- DATA:
  - On each strobe, shift RX_safe into the MSB of the shift register (LSB-first reception) and increment the bit counter.
  - After the DATA_BITS-th sample, go to PAR if PARITY != 0, otherwise to STOP.
- PAR: on the strobe, capture the parity bit, then go to STOP.
  - Even mode: error if XOR of data bits and parity bit = 1.
  - Odd mode: error if that XOR = 0.
- STOP: on the strobe (mid stop bit), go to IDLE. On the following clock edge:
  - rx_data <= shift register.
  - rdy <= 1.
  - frame_err <= ~RX_safe at the sample.
  - parity_err <= computed error, or 0 when PARITY = 0.
  - overrun <= 1 if rdy was 1 at that edge and clr_rdy was not asserted in the same cycle.
  - The frame is delivered even when frame_err or parity_err is set.
- Latency: rdy rises 1 clk after the mid-stop strobe. From the start edge on RX_safe, that is BAUD_DIV/2 + (1 + DATA_BITS + (PARITY != 0)) * BAUD_DIV + 1 clk.
- clr_rdy:
  - Clears rdy and overrun the next cycle.
  - parity_err and frame_err hold until the next frame completes.
  - If clr_rdy and frame completion occur in the same cycle, completion wins: rdy = 1, overrun = 0.
- Back-to-back frames: the receiver returns to IDLE at mid-stop, so it accepts a start edge in the second half of the stop bit.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded.
- Bit counter width: $clog2(DATA_BITS+1).

Test Plan:
1. BAUD_DIV=16, DATA_BITS=8, PARITY=0; send 0xA5 with a valid stop bit -> rdy=1, rx_data=0xA5, both error flags 0, rdy rises 153 clk after the RX_safe falling edge; pulse clr_rdy -> rdy=0 the next cycle.
2. PARITY=1; send 0x37 with parity bit 1 (correct even parity) -> parity_err=0. Resend 0x37 with parity bit 0 -> rdy=1, parity_err=1, rx_data=0x37.
3. Send 0x5A with the stop bit driven low, then hold RX low for 5 bit times -> frame_err=1, rx_data=0x5A, exactly one rdy; no new frame starts until RX goes high and then falls again.
4. Drive RX low for 3 clk (shorter than BAUD_DIV/2 after synchronisation), then high -> state returns to IDLE, rdy stays 0, no flag changes.
5. Send 0x11 then 0x22 back-to-back without clr_rdy -> rx_data=0x22, overrun=1. Repeat with clr_rdy asserted in the same cycle as the second completion -> rdy=1, overrun=0.
6. DATA_BITS=7, PARITY=2; send 0x7F with parity bit 0 (correct odd parity: seven ones) -> rx_data=0x7F, parity_err=0. Assert rst_n low mid-DATA -> all outputs 0 and state IDLE immediately; a following frame 0x01 is received correctly.
